// File: rtl/tm_queue_association_mem_if.sv
// TM queue-association table bus: datapath read port and PIO register port.
// master: accessor/software side, slave: the table (parity_err with QUEUE_ASSOCIATION_PARITY_EN).
interface tm_queue_association_mem_if #(
  parameter int ADDR_NBITS = 4,
  parameter int DATA_NBITS = 16
);
`ifdef QUEUE_ASSOCIATION_PARITY_EN
  localparam int PIO_NBITS = DATA_NBITS + 1;
`else
  localparam int PIO_NBITS = DATA_NBITS;
`endif

  logic                  queue_association_rd;
  logic [ADDR_NBITS-1:0] queue_association_raddr;
  logic                  queue_association_ack;
  logic [DATA_NBITS-1:0] queue_association_rdata;
  logic                  reg_ms_queue_association;
  logic                  reg_rd;
  logic                  reg_wr;
  logic [ADDR_NBITS-1:0] reg_addr;
  logic [DATA_NBITS-1:0] reg_din;
  logic                  queue_association_mem_ack;
  logic [PIO_NBITS-1:0]  queue_association_mem_rdata;
`ifdef QUEUE_ASSOCIATION_PARITY_EN
  logic                  parity_err;

  modport master (
    output queue_association_rd, queue_association_raddr,
    output reg_ms_queue_association, reg_rd, reg_wr,
    output reg_addr, reg_din,
    input  queue_association_ack, queue_association_rdata,
    input  queue_association_mem_ack, queue_association_mem_rdata,
    input  parity_err
  );

  modport slave (
    input  queue_association_rd, queue_association_raddr,
    input  reg_ms_queue_association, reg_rd, reg_wr,
    input  reg_addr, reg_din,
    output queue_association_ack, queue_association_rdata,
    output queue_association_mem_ack, queue_association_mem_rdata,
    output parity_err
  );
`else
  modport master (
    output queue_association_rd, queue_association_raddr,
    output reg_ms_queue_association, reg_rd, reg_wr,
    output reg_addr, reg_din,
    input  queue_association_ack, queue_association_rdata,
    input  queue_association_mem_ack, queue_association_mem_rdata
  );

  modport slave (
    input  queue_association_rd, queue_association_raddr,
    input  reg_ms_queue_association, reg_rd, reg_wr,
    input  reg_addr, reg_din,
    output queue_association_ack, queue_association_rdata,
    output queue_association_mem_ack, queue_association_mem_rdata
  );
`endif
endinterface

// File: rtl/tm_queue_association_mem.sv
// TM queue-association table: cleared after reset, fixed-latency datapath reads, PIO access.
// Ports: clk, rst_n, bus (slave), init_done, init_rd_drop. Option: QUEUE_ASSOCIATION_PARITY_EN.
module tm_queue_association_mem #(
  parameter int ADDR_NBITS = 4,
  parameter int DATA_NBITS = 16,
  parameter int DEPTH      = 1 << ADDR_NBITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  tm_queue_association_mem_if.slave bus,
  output logic                      init_done,
  output logic                      init_rd_drop
);
`ifdef QUEUE_ASSOCIATION_PARITY_EN
  localparam int MEM_NBITS = DATA_NBITS + 1;
`else
  localparam int MEM_NBITS = DATA_NBITS;
`endif

  typedef enum logic {S_INIT, S_RUN} init_st_e;
  typedef enum logic [1:0] {
    PIO_IDLE, PIO_WAIT, PIO_RESP
  } pio_st_e;

  init_st_e init_st_q, init_st_d;
  pio_st_e  pio_st_q, pio_st_d;

  logic [ADDR_NBITS-1:0] cnt_q, cnt_d;
  logic                  pend_v_q, pend_v_d;
  logic [ADDR_NBITS-1:0] pend_addr_q, pend_addr_d;
  logic                  drop_q, drop_d;
  logic                  done_q;

  logic                  pio_wr_q;
  logic [ADDR_NBITS-1:0] pio_addr_q;
  logic [DATA_NBITS-1:0] pio_din_q;
  logic [MEM_NBITS-1:0]  pio_wdata;

  logic                  dp_rd_q;
  logic                  pio_rd_q;
  logic                  ack_q;
  logic [DATA_NBITS-1:0] rdata_q;
  logic                  mem_ack_q;
  logic [DATA_NBITS-1:0] mem_rdata_q;

  logic [MEM_NBITS-1:0]  mem_q [DEPTH];
  logic [MEM_NBITS-1:0]  ram_q;

  logic                  run;
  logic                  pio_req;
  logic                  dp_issue;
  logic                  pio_issue;
  logic                  ram_we;
  logic [ADDR_NBITS-1:0] ram_addr;
  logic [MEM_NBITS-1:0]  ram_wdata;

  assign run     = (init_st_q == S_RUN);
  assign pio_req = bus.reg_ms_queue_association
                 & (bus.reg_rd | bus.reg_wr);

`ifdef QUEUE_ASSOCIATION_PARITY_EN
  assign pio_wdata = {^pio_din_q, pio_din_q};
`else
  assign pio_wdata = pio_din_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_st_q   <= S_INIT;
      pio_st_q    <= PIO_IDLE;
      cnt_q       <= '0;
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      drop_q      <= 1'b0;
      done_q      <= 1'b0;
      pio_wr_q    <= 1'b0;
      pio_addr_q  <= '0;
      pio_din_q   <= '0;
      dp_rd_q     <= 1'b0;
      pio_rd_q    <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      mem_ack_q   <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      init_st_q   <= init_st_d;
      pio_st_q    <= pio_st_d;
      cnt_q       <= cnt_d;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      drop_q      <= drop_d;
      done_q      <= run;
      if (pio_st_q == PIO_IDLE && pio_req) begin
        // both strobes together count as a write
        pio_wr_q   <= bus.reg_wr;
        pio_addr_q <= bus.reg_addr;
        pio_din_q  <= bus.reg_din;
      end
      dp_rd_q   <= dp_issue;
      pio_rd_q  <= pio_issue & ~pio_wr_q;
      ack_q     <= dp_rd_q;
      if (dp_rd_q) rdata_q <= ram_q[DATA_NBITS-1:0];
      mem_ack_q <= pio_rd_q | (pio_issue & pio_wr_q);
      if (pio_rd_q) mem_rdata_q <= ram_q[DATA_NBITS-1:0];
    end
  end

  always_comb begin
    init_st_d   = init_st_q;
    pio_st_d    = pio_st_q;
    cnt_d       = cnt_q;
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    drop_d      = drop_q;
    if (!run) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == ADDR_NBITS'(DEPTH - 1)) init_st_d = S_RUN;
      if (bus.queue_association_rd) begin
        if (pend_v_q) begin
          drop_d = 1'b1;
        end else begin
          pend_v_d    = 1'b1;
          pend_addr_d = bus.queue_association_raddr;
        end
      end
    end else if (pend_v_q) begin
      // pending is served now; a colliding rd takes its slot
      pend_v_d = bus.queue_association_rd;
      if (bus.queue_association_rd)
        pend_addr_d = bus.queue_association_raddr;
    end
    unique case (pio_st_q)
      PIO_IDLE: if (pio_req) pio_st_d = PIO_WAIT;
      PIO_WAIT: if (pio_issue)
        pio_st_d = pio_wr_q ? PIO_IDLE : PIO_RESP;
      PIO_RESP: pio_st_d = PIO_IDLE;
      default:  pio_st_d = PIO_IDLE;
    endcase
  end

  // single RAM port: init, then pending, then new rd, then PIO
  always_comb begin
    dp_issue  = 1'b0;
    pio_issue = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = bus.queue_association_raddr;
    ram_wdata = '0;
    unique case (1'b1)
      !run: begin
        ram_we   = 1'b1;
        ram_addr = cnt_q;
      end
      run && pend_v_q: begin
        dp_issue = 1'b1;
        ram_addr = pend_addr_q;
      end
      run && !pend_v_q && bus.queue_association_rd: begin
        dp_issue = 1'b1;
      end
      run && !pend_v_q && !bus.queue_association_rd
          && pio_st_q == PIO_WAIT: begin
        pio_issue = 1'b1;
        ram_we    = pio_wr_q;
        ram_addr  = pio_addr_q;
        ram_wdata = pio_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem_q[ram_addr] <= ram_wdata;
    else        ram_q <= mem_q[ram_addr];
  end

`ifdef QUEUE_ASSOCIATION_PARITY_EN
  logic perr_q;
  logic psticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q    <= 1'b0;
      psticky_q <= 1'b0;
    end else begin
      perr_q <= dp_rd_q & (^ram_q);
      if (pio_issue & pio_wr_q)
        psticky_q <= 1'b0;
      else if (dp_rd_q & (^ram_q))
        psticky_q <= 1'b1;
    end
  end

  assign bus.parity_err = perr_q;
  assign bus.queue_association_mem_rdata = {psticky_q, mem_rdata_q};
`else
  assign bus.queue_association_mem_rdata = mem_rdata_q;
`endif

  assign bus.queue_association_ack   = ack_q;
  assign bus.queue_association_rdata = rdata_q;
  assign bus.queue_association_mem_ack = mem_ack_q;
  assign init_done    = done_q;
  assign init_rd_drop = drop_q;

endmodule

// File: tb/tb_tm_queue_association_mem.sv
// Directed bench for tm_queue_association_mem: init, datapath reads, PIO, arbitration.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_tm_queue_association_mem;
  logic clk;
  logic rst_n;
  logic init_done;
  logic init_rd_drop;
  int   checks;
  int   errors;

  tm_queue_association_mem_if #(
    .ADDR_NBITS(4), .DATA_NBITS(16)
  ) bus ();

  tm_queue_association_mem #(
    .ADDR_NBITS(4), .DATA_NBITS(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .init_done   (init_done),
    .init_rd_drop(init_rd_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic idle_inputs();
    bus.queue_association_rd     = 1'b0;
    bus.queue_association_raddr  = '0;
    bus.reg_ms_queue_association = 1'b0;
    bus.reg_rd   = 1'b0;
    bus.reg_wr   = 1'b0;
    bus.reg_addr = '0;
    bus.reg_din  = '0;
  endtask

  // leaves the bench in cycle 0 after reset release
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pio_write(input logic [3:0] a,
                           input logic [15:0] d,
                           output bit got);
    bus.reg_ms_queue_association = 1'b1;
    bus.reg_wr   = 1'b1;
    bus.reg_addr = a;
    bus.reg_din  = d;
    @(negedge clk);
    bus.reg_ms_queue_association = 1'b0;
    bus.reg_wr = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus.queue_association_mem_ack === 1'b1) got = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic pio_read(input logic [3:0] a,
                          output logic [15:0] d,
                          output bit got);
    bus.reg_ms_queue_association = 1'b1;
    bus.reg_rd   = 1'b1;
    bus.reg_addr = a;
    @(negedge clk);
    bus.reg_ms_queue_association = 1'b0;
    bus.reg_rd = 1'b0;
    got = 1'b0;
    d   = 'x;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus.queue_association_mem_ack === 1'b1) begin
        got = 1'b1;
        d   = bus.queue_association_mem_rdata[15:0];
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks += 6;
    if (bus.queue_association_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack: got %b want 0", bus.queue_association_ack);
    end
    if (bus.queue_association_rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h want 0", bus.queue_association_rdata);
    end
    if (bus.queue_association_mem_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_mem_ack: got %b want 0", bus.queue_association_mem_ack);
    end
    if (bus.queue_association_mem_rdata[15:0] !== 16'h0) begin
      errors++;
      $display("FAIL reset_mem_rdata: got %h want 0",
               bus.queue_association_mem_rdata);
    end
    if (init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_init_done: got %b want 0", init_done);
    end
    if (init_rd_drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_init_rd_drop: got %b want 0", init_rd_drop);
    end
  endtask

  task automatic test_init();
    logic [15:0] d;
    bit got;
    do_reset();
    for (int c = 0; c < 18; c++) begin
      if (c != 16) begin
        checks++;
        if (init_done !== (c == 17)) begin
          errors++;
          $display("FAIL init_done_c%0d: got %b want %b", c, init_done, c == 17);
        end
      end
      @(negedge clk);
    end
    for (int i = 0; i < 16; i++) begin
      pio_read(4'(i), d, got);
      checks++;
      if (!got || d !== 16'h0) begin
        errors++;
        $display("FAIL init_clear_idx%0d: got %h ack %b want 0", i, d, got);
      end
    end
  endtask

  task automatic test_pio_dp();
    bit got;
    pio_write(4'd5, 16'h01A3, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL pio_wr5_ack: got none want mem_ack");
    end
    bus.queue_association_rd    = 1'b1;
    bus.queue_association_raddr = 4'd5;
    @(negedge clk);
    bus.queue_association_rd = 1'b0;
    checks++;
    if (bus.queue_association_ack !== 1'b0) begin
      errors++;
      $display("FAIL dp_ack_n1: got %b want 0", bus.queue_association_ack);
    end
    @(negedge clk);
    checks += 2;
    if (bus.queue_association_ack !== 1'b1) begin
      errors++;
      $display("FAIL dp_ack_n2: got %b want 1", bus.queue_association_ack);
    end
    if (bus.queue_association_rdata !== 16'h01A3) begin
      errors++;
      $display("FAIL dp_rdata_n2: got %h want 01a3", bus.queue_association_rdata);
    end
    @(negedge clk);
    checks += 2;
    if (bus.queue_association_ack !== 1'b0) begin
      errors++;
      $display("FAIL dp_ack_n3: got %b want 0", bus.queue_association_ack);
    end
    if (bus.queue_association_rdata !== 16'h01A3) begin
      errors++;
      $display("FAIL dp_rdata_hold: got %h want 01a3", bus.queue_association_rdata);
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    bit exp_ack;
    for (int i = 0; i < 16; i++) begin
      pio_write(4'(i), 16'(i * 3), got);
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL b2b_wr_idx%0d: got no ack want mem_ack", i);
      end
    end
    for (int c = 0; c < 20; c++) begin
      bus.queue_association_rd    = (c < 16);
      bus.queue_association_raddr = 4'(c);
      exp_ack = (c >= 2 && c < 18);
      checks++;
      if (bus.queue_association_ack !== exp_ack) begin
        errors++;
        $display("FAIL b2b_ack_c%0d: got %b want %b", c,
                 bus.queue_association_ack, exp_ack);
      end
      if (exp_ack) begin
        checks++;
        if (bus.queue_association_rdata !== 16'((c - 2) * 3)) begin
          errors++;
          $display("FAIL b2b_rdata_c%0d: got %h want %h", c,
                   bus.queue_association_rdata, 16'((c - 2) * 3));
        end
      end
      @(negedge clk);
    end
    bus.queue_association_rd = 1'b0;
  endtask

  task automatic test_pio_arb();
    logic [15:0] d;
    bit got;
    bit exp_ack;
    bit exp_mack;
    for (int c = 0; c < 9; c++) begin
      bus.queue_association_rd    = (c < 4);
      bus.queue_association_raddr = 4'(c + 2);
      bus.reg_ms_queue_association = (c < 2);
      bus.reg_rd   = (c == 0);
      bus.reg_wr   = (c == 1);
      bus.reg_addr = 4'd7;
      bus.reg_din  = 16'h0FFF;
      exp_ack  = (c >= 2 && c < 6);
      exp_mack = (c == 6);
      checks += 2;
      if (bus.queue_association_ack !== exp_ack) begin
        errors++;
        $display("FAIL arb_ack_c%0d: got %b want %b", c,
                 bus.queue_association_ack, exp_ack);
      end
      if (bus.queue_association_mem_ack !== exp_mack) begin
        errors++;
        $display("FAIL arb_mem_ack_c%0d: got %b want %b", c,
                 bus.queue_association_mem_ack, exp_mack);
      end
      if (exp_ack) begin
        checks++;
        if (bus.queue_association_rdata !== 16'(c * 3)) begin
          errors++;
          $display("FAIL arb_rdata_c%0d: got %h want %h", c,
                   bus.queue_association_rdata, 16'(c * 3));
        end
      end
      if (exp_mack) begin
        checks++;
        if (bus.queue_association_mem_rdata[15:0] !== 16'd21) begin
          errors++;
          $display("FAIL arb_mem_rdata: got %h want 0015",
                   bus.queue_association_mem_rdata);
        end
      end
      @(negedge clk);
    end
    idle_inputs();
    pio_read(4'd7, d, got);
    checks++;
    if (!got || d !== 16'd21) begin
      errors++;
      $display("FAIL arb_ignored_wr: got %h ack %b want 0015", d, got);
    end
  endtask

  task automatic test_pio_corner();
    logic [15:0] d;
    bit got;
    bus.reg_ms_queue_association = 1'b1;
    bus.reg_rd   = 1'b1;
    bus.reg_wr   = 1'b1;
    bus.reg_addr = 4'd10;
    bus.reg_din  = 16'h0055;
    @(negedge clk);
    idle_inputs();
    checks++;
    if (bus.queue_association_mem_ack !== 1'b0) begin
      errors++;
      $display("FAIL rdwr_ack_s1: got %b want 0", bus.queue_association_mem_ack);
    end
    @(negedge clk);
    checks++;
    if (bus.queue_association_mem_ack !== 1'b1) begin
      errors++;
      $display("FAIL rdwr_ack_s2: got %b want 1", bus.queue_association_mem_ack);
    end
    @(negedge clk);
    pio_read(4'd10, d, got);
    checks++;
    if (!got || d !== 16'h0055) begin
      errors++;
      $display("FAIL rdwr_as_write: got %h ack %b want 0055", d, got);
    end
  endtask

  task automatic test_collision();
    bus.reg_ms_queue_association = 1'b1;
    bus.reg_wr   = 1'b1;
    bus.reg_addr = 4'd8;
    bus.reg_din  = 16'h00F0;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    bus.queue_association_rd    = 1'b1;
    bus.queue_association_raddr = 4'd8;
    checks++;
    if (bus.queue_association_mem_ack !== 1'b1) begin
      errors++;
      $display("FAIL coll_wr_ack: got %b want 1", bus.queue_association_mem_ack);
    end
    @(negedge clk);
    bus.queue_association_rd = 1'b0;
    @(negedge clk);
    checks += 2;
    if (bus.queue_association_ack !== 1'b1) begin
      errors++;
      $display("FAIL coll_ack: got %b want 1", bus.queue_association_ack);
    end
    if (bus.queue_association_rdata !== 16'h00F0) begin
      errors++;
      $display("FAIL coll_rdata: got %h want 00f0", bus.queue_association_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    bus.queue_association_rd     = 1'b1;
    bus.queue_association_raddr  = 4'd1;
    bus.reg_ms_queue_association = 1'b1;
    bus.reg_rd   = 1'b1;
    bus.reg_addr = 4'd1;
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) rst_n = 1'b1;
      checks++;
      if (bus.queue_association_ack !== 1'b0 ||
          bus.queue_association_mem_ack !== 1'b0) begin
        errors++;
        $display("FAIL midrst_c%0d: got ack %b mem_ack %b want 0 0", c,
                 bus.queue_association_ack, bus.queue_association_mem_ack);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_init_pending();
    bit exp_ack;
    do_reset();
    for (int c = 0; c < 25; c++) begin
      bus.queue_association_rd    = (c == 3 || c == 5);
      bus.queue_association_raddr = (c == 3) ? 4'd9 : 4'd4;
      exp_ack = (c == 18);
      checks++;
      if (bus.queue_association_ack !== exp_ack) begin
        errors++;
        $display("FAIL pend_ack_c%0d: got %b want %b", c,
                 bus.queue_association_ack, exp_ack);
      end
      if (exp_ack) begin
        checks++;
        if (bus.queue_association_rdata !== 16'h0) begin
          errors++;
          $display("FAIL pend_rdata: got %h want 0", bus.queue_association_rdata);
        end
      end
      if (c == 4 || c == 24) begin
        checks++;
        if (init_rd_drop !== (c == 24)) begin
          errors++;
          $display("FAIL pend_drop_c%0d: got %b want %b", c,
                   init_rd_drop, c == 24);
        end
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_init_priority();
    bit exp_ack;
    do_reset();
    for (int c = 0; c < 24; c++) begin
      bus.queue_association_rd    = (c == 10 || c == 16);
      bus.queue_association_raddr = (c == 10) ? 4'd2 : 4'd6;
      exp_ack = (c == 18 || c == 19);
      checks++;
      if (bus.queue_association_ack !== exp_ack) begin
        errors++;
        $display("FAIL prio_ack_c%0d: got %b want %b", c,
                 bus.queue_association_ack, exp_ack);
      end
      @(negedge clk);
    end
    idle_inputs();
    checks++;
    if (init_rd_drop !== 1'b0) begin
      errors++;
      $display("FAIL prio_drop: got %b want 0", init_rd_drop);
    end
  endtask

`ifdef QUEUE_ASSOCIATION_PARITY_EN
  task automatic test_parity();
    logic [15:0] d;
    bit got;
    bit exp;
    pio_write(4'd3, 16'h00A5, got);
    dut.mem_q[3][16] = ~dut.mem_q[3][16];
    for (int c = 0; c < 4; c++) begin
      bus.queue_association_rd    = (c == 0);
      bus.queue_association_raddr = 4'd3;
      exp = (c == 2);
      checks++;
      if (bus.parity_err !== exp || bus.queue_association_ack !== exp) begin
        errors++;
        $display("FAIL par_err_c%0d: got perr %b ack %b want %b", c,
                 bus.parity_err, bus.queue_association_ack, exp);
      end
      @(negedge clk);
    end
    idle_inputs();
    pio_read(4'd0, d, got);
    checks++;
    if (bus.queue_association_mem_rdata[16] !== 1'b1) begin
      errors++;
      $display("FAIL par_sticky_set: got %b want 1",
               bus.queue_association_mem_rdata[16]);
    end
    pio_write(4'd0, 16'h0, got);
    checks++;
    if (bus.queue_association_mem_rdata[16] !== 1'b0) begin
      errors++;
      $display("FAIL par_sticky_clr: got %b want 0",
               bus.queue_association_mem_rdata[16]);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_init();
    test_pio_dp();
    test_back_to_back();
    test_pio_arb();
    test_pio_corner();
    test_collision();
    test_reset_midop();
    test_init_pending();
    test_init_priority();
`ifdef QUEUE_ASSOCIATION_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tm_queue_association_mem.md
Name: tm_queue_association_mem

Overview:
- Responder and storage for the TM queue-association table, indexed by first-level queue id.
- Serves datapath read requests from the TM association accessor with fixed latency: queue_association_rd/raddr in, queue_association_ack/rdata out.
- Provides a PIO register port so software can program and read back entries.
- Clears the whole table after reset before normal operation.

Parameters:
- ADDR_NBITS, `FIRST_LVL_QUEUE_ID_NBITS, table index width.
- DATA_NBITS, `QUEUE_ASSOCIATION_NBITS, entry width, packed as {port, port_queue, conn_group, conn}.
- DEPTH, (1<<ADDR_NBITS), number of entries.

Ports:
- clk  in  1  core clock.
- `RESET_SIG  in  1  asynchronous active-low reset (resetn), via the codebase reset macro.
- queue_association_rd  in  1  datapath read strobe, single-cycle.
- queue_association_raddr  in  ADDR_NBITS  datapath read index.
- queue_association_ack  out  1  datapath read-data valid, single-cycle.
- queue_association_rdata  out  DATA_NBITS  datapath read data.
- reg_ms_queue_association  in  1  PIO select for this table.
- reg_rd  in  1  PIO read strobe.
- reg_wr  in  1  PIO write strobe.
- reg_addr  in  ADDR_NBITS  PIO index.
- reg_din  in  DATA_NBITS  PIO write data.
- queue_association_mem_ack  out  1  PIO completion pulse.
- queue_association_mem_rdata  out  DATA_NBITS  PIO read data.
- init_done  out  1  table clear complete.
- init_rd_drop  out  1  sticky: datapath read lost during init.

Behaviour:
- Reset values: every output is 0. Reset enters INIT with clear counter 0.
- Storage is a single-port RAM with a registered read (1-cycle).
- Init FSM, INIT -> RUN:
  - INIT writes 0 to index = counter each cycle; counter increments.
  - Leaves INIT after writing DEPTH-1 (DEPTH cycles total).
  - init_done rises 1 cycle later and stays 1 until reset.
- Datapath read, RUN:
  - rd at cycle N -> RAM read at N.
  - ack=1 with rdata at N+2, from the output register.
  - Back-to-back rd every cycle is supported, full throughput.
  - rdata holds its last value when ack=0.
- Datapath read during INIT:
  - One-entry pending register captures raddr.
  - Served on the first RUN cycle; ack 2 cycles later.
  - A second rd during INIT while pending is valid is dropped and sets init_rd_drop (sticky until reset).
  - A pending request takes priority over a new rd on the first RUN cycle. That new rd is also held in the pending register and served the next cycle.
- PIO:
  - A request is valid when reg_ms_queue_association & (reg_rd | reg_wr), single-cycle strobes.
  - It is latched into a PIO holding register, state PIO_IDLE -> PIO_WAIT.
  - PIO_WAIT issues to RAM on the first RUN cycle with no datapath/pending read. A datapath read always wins.
  - Write: RAM written that cycle; mem_ack pulses the next cycle.
  - Read: mem_rdata is valid with a mem_ack pulse 2 cycles after issue, then PIO_IDLE.
  - New PIO strobes while not in PIO_IDLE are ignored, since the PIO master issues one outstanding access.
  - reg_rd and reg_wr together are treated as a write.
- Read/write collision: a PIO write to index X followed next cycle by a datapath read of X returns the new data.
- Reset mid-operation:
  - Pending, PIO and ack pipelines are cleared; no ack is emitted for in-flight requests.
  - Table contents are re-cleared by INIT.

Optional Feature:
- QUEUE_ASSOCIATION_PARITY_EN defined:
  - Each entry stores one extra even-parity bit over the data, generated on PIO and INIT writes.
  - Parity is checked on every datapath read.
  - On mismatch, output parity_err (1 bit, reset 0) pulses aligned with ack, and a sticky status bit is readable in bit DATA_NBITS of mem_rdata. That bit is cleared by a PIO write to any index.
- Undefined: no parity storage, no parity_err port, and mem_rdata is exactly DATA_NBITS.

Test Plan:
- Bench uses ADDR_NBITS=4.
- Release reset, no traffic -> init_done=0 for cycles 0..15, 1 from cycle 17. PIO read of all 16 indexes returns 0.
- PIO write idx 5 = 0x1A3, then datapath rd raddr=5 at cycle N -> ack=1 at N+2 with rdata=0x1A3. No ack at N+1 or N+3.
- Datapath rd every cycle for idx 0..15 (pre-written as idx*3) -> 16 consecutive acks with data 0,3,...,45 in order.
- PIO read idx 7 in the same cycle as datapath rd idx 2, with datapath reads continuing 3 more cycles -> the 4 datapath acks come first. mem_ack arrives 2 cycles after the first idle cycle.
- rd raddr=9 at cycle 3 after reset, then rd raddr=4 at cycle 5 -> a single ack for idx 9 with data 0 after init, and init_rd_drop=1.
- With QUEUE_ASSOCIATION_PARITY_EN: force a parity bit flip in RAM for idx 3, then datapath rd idx 3 -> parity_err pulses with ack and the sticky bit reads 1. A subsequent PIO write clears it.
